// File: rtl/huffman_ctrl.sv
// -----------------------------------------------------------------------------
// huffman_ctrl
//
// Frame-level sequencer for the huffman coding core (Counter, Sorting,
// TreeMaker, CodeSender). It takes a pixel frame from the host over a
// valid/ready handshake, holds the core in reset between frames, streams
// exactly FRAME_LEN pixels to the core as one contiguous gray_valid burst,
// watches the core's completion flags with a watchdog, and then holds the
// results for the host until they are acknowledged.
//
// Parameters:
//   FRAME_LEN  pixels per frame (1..65535)
//   TIMEOUT    max cycles to wait for each core completion flag (1..65535)
//
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   start               begin a new frame (honoured only in IDLE or ERR)
//   pix_valid/pix_data  host pixel stream; pix_ready = pixel accepted
//   core_rst            reset to the huffman core
//   core_gray_valid/core_gray_data  pixel stream into the core
//   core_cnt_valid, core_code_valid completion flags from the core
//   busy                high in every state except IDLE and ERR
//   res_valid/res_ack   result hand-over to the host
//   err, err_code       sticky error (1 underrun, 2 count timeout,
//                       3 code timeout)
//   frame_cnt           completed frames, wraps 255->0
//   perf_cycles         (only with HUFF_CTRL_PERF_EN) cycles from the first
//                       FEED cycle through the cycle code_valid is seen,
//                       saturating at 65535
//
// Optional feature macro: HUFF_CTRL_PERF_EN
// -----------------------------------------------------------------------------
module huffman_ctrl #(
    parameter int unsigned FRAME_LEN = 100,
    parameter int unsigned TIMEOUT   = 255
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       pix_valid,
    input  logic [7:0] pix_data,
    output logic       pix_ready,
    output logic       core_rst,
    output logic       core_gray_valid,
    output logic [7:0] core_gray_data,
    input  logic       core_cnt_valid,
    input  logic       core_code_valid,
    output logic       busy,
    output logic       res_valid,
    input  logic       res_ack,
    output logic       err,
    output logic [1:0] err_code,
    output logic [7:0] frame_cnt
`ifdef HUFF_CTRL_PERF_EN
    ,
    output logic [15:0] perf_cycles
`endif
);

    localparam logic [15:0] FRAME_LEN_W = 16'(FRAME_LEN);
    localparam logic [15:0] TIMEOUT_W   = 16'(TIMEOUT);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLR,
        S_FEED,
        S_WAIT_CNT,
        S_WAIT_CODE,
        S_HOLD,
        S_ERR
    } state_t;

    state_t      state_q, state_d;
    logic        clr_cnt_q, clr_cnt_d;
    logic [15:0] pix_cnt_q, pix_cnt_d;
    logic [15:0] timer_q, timer_d;
    logic        code_seen_q, code_seen_d;
    logic        pix_ready_q, pix_ready_d;
    logic        core_rst_q, core_rst_d;
    logic        gray_valid_q, gray_valid_d;
    logic [7:0]  gray_data_q, gray_data_d;
    logic        busy_q, busy_d;
    logic        res_valid_q, res_valid_d;
    logic        err_q, err_d;
    logic [1:0]  err_code_q, err_code_d;
    logic [7:0]  frame_cnt_q, frame_cnt_d;
    logic        pix_hs;
`ifdef HUFF_CTRL_PERF_EN
    logic [15:0] perf_q, perf_d;
`endif

    assign pix_hs = (state_q == S_FEED) && pix_valid && pix_ready_q;

    always_comb begin
        state_d     = state_q;
        clr_cnt_d   = clr_cnt_q;
        pix_cnt_d   = pix_cnt_q;
        timer_d     = timer_q;
        code_seen_d = code_seen_q;
        err_d       = err_q;
        err_code_d  = err_code_q;
        frame_cnt_d = frame_cnt_q;

        case (state_q)
            S_IDLE: begin
                if (start) state_d = S_CLR;
            end
            S_CLR: begin
                pix_cnt_d   = '0;
                timer_d     = '0;
                code_seen_d = 1'b0;
                err_d       = 1'b0;
                err_code_d  = 2'd0;
                clr_cnt_d   = 1'b1;
                if (clr_cnt_q) begin
                    clr_cnt_d = 1'b0;
                    state_d   = S_FEED;
                end
            end
            S_FEED: begin
                if (pix_hs) begin
                    pix_cnt_d = pix_cnt_q + 16'd1;
                    if (pix_cnt_q == FRAME_LEN_W - 16'd1) begin
                        timer_d = '0;
                        state_d = S_WAIT_CNT;
                    end
                end else if (pix_ready_q && pix_cnt_q != 16'd0) begin
                    // The burst must be contiguous once the first pixel is in.
                    err_d      = 1'b1;
                    err_code_d = 2'd1;
                    state_d    = S_ERR;
                end
            end
            S_WAIT_CNT: begin
                timer_d = timer_q + 16'd1;
                // An early code_valid must not be lost while counts finish.
                if (core_code_valid) code_seen_d = 1'b1;
                if (core_cnt_valid) begin
                    timer_d = '0;
                    state_d = S_WAIT_CODE;
                end else if (timer_q == TIMEOUT_W) begin
                    err_d      = 1'b1;
                    err_code_d = 2'd2;
                    state_d    = S_ERR;
                end
            end
            S_WAIT_CODE: begin
                timer_d = timer_q + 16'd1;
                if (core_code_valid || code_seen_q) begin
                    state_d = S_HOLD;
                end else if (timer_q == TIMEOUT_W) begin
                    err_d      = 1'b1;
                    err_code_d = 2'd3;
                    state_d    = S_ERR;
                end
            end
            S_HOLD: begin
                if (res_ack) begin
                    frame_cnt_d = frame_cnt_q + 8'd1;
                    state_d     = S_IDLE;
                end
            end
            S_ERR: begin
                if (start) state_d = S_CLR;
            end
            default: state_d = S_IDLE;
        endcase

        // Outputs are registered from the next state so they line up with it.
        pix_ready_d  = (state_d == S_FEED) && (pix_cnt_d < FRAME_LEN_W);
        core_rst_d   = (state_d == S_IDLE) || (state_d == S_CLR) || (state_d == S_ERR);
        busy_d       = !((state_d == S_IDLE) || (state_d == S_ERR));
        res_valid_d  = (state_d == S_HOLD);
        gray_valid_d = pix_hs;
        gray_data_d  = pix_hs ? pix_data : gray_data_q;
    end

`ifdef HUFF_CTRL_PERF_EN
    always_comb begin
        perf_d = perf_q;
        if (state_q == S_CLR) begin
            perf_d = '0;
        end else if ((state_q == S_FEED) || (state_q == S_WAIT_CNT) ||
                     (state_q == S_WAIT_CODE)) begin
            if (perf_q != 16'hFFFF) perf_d = perf_q + 16'd1;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            clr_cnt_q    <= 1'b0;
            pix_cnt_q    <= '0;
            timer_q      <= '0;
            code_seen_q  <= 1'b0;
            pix_ready_q  <= 1'b0;
            core_rst_q   <= 1'b1;
            gray_valid_q <= 1'b0;
            gray_data_q  <= '0;
            busy_q       <= 1'b0;
            res_valid_q  <= 1'b0;
            err_q        <= 1'b0;
            err_code_q   <= 2'd0;
            frame_cnt_q  <= '0;
`ifdef HUFF_CTRL_PERF_EN
            perf_q       <= '0;
`endif
        end else begin
            state_q      <= state_d;
            clr_cnt_q    <= clr_cnt_d;
            pix_cnt_q    <= pix_cnt_d;
            timer_q      <= timer_d;
            code_seen_q  <= code_seen_d;
            pix_ready_q  <= pix_ready_d;
            core_rst_q   <= core_rst_d;
            gray_valid_q <= gray_valid_d;
            gray_data_q  <= gray_data_d;
            busy_q       <= busy_d;
            res_valid_q  <= res_valid_d;
            err_q        <= err_d;
            err_code_q   <= err_code_d;
            frame_cnt_q  <= frame_cnt_d;
`ifdef HUFF_CTRL_PERF_EN
            perf_q       <= perf_d;
`endif
        end
    end

    assign pix_ready       = pix_ready_q;
    assign core_rst        = core_rst_q;
    assign core_gray_valid = gray_valid_q;
    assign core_gray_data  = gray_data_q;
    assign busy            = busy_q;
    assign res_valid       = res_valid_q;
    assign err             = err_q;
    assign err_code        = err_code_q;
    assign frame_cnt       = frame_cnt_q;
`ifdef HUFF_CTRL_PERF_EN
    assign perf_cycles     = perf_q;
`endif

endmodule

// File: tb/tb_huffman_ctrl.sv
// -----------------------------------------------------------------------------
// tb_huffman_ctrl
//
// Directed bench for huffman_ctrl. Stimulus pushes the expected pixel stream
// (data and arrival cycle) and the expected frame outcome into queues; a
// monitor on the falling edge pops and compares whenever the DUT presents a
// pixel to the core, raises res_valid, or raises err.
// -----------------------------------------------------------------------------
module tb_huffman_ctrl;

    localparam int FL = 100;
    localparam int TO = 10;

    logic       clk = 1'b0;
    logic       reset, start, pix_valid, pix_ready, core_rst;
    logic [7:0] pix_data, core_gray_data, frame_cnt;
    logic       core_gray_valid, core_cnt_valid, core_code_valid;
    logic       busy, res_valid, res_ack, err;
    logic [1:0] err_code;
`ifdef HUFF_CTRL_PERF_EN
    logic [15:0] perf_cycles;
`endif

    always #5 clk = ~clk;

    huffman_ctrl #(.FRAME_LEN(FL), .TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset), .start(start),
        .pix_valid(pix_valid), .pix_data(pix_data), .pix_ready(pix_ready),
        .core_rst(core_rst), .core_gray_valid(core_gray_valid),
        .core_gray_data(core_gray_data), .core_cnt_valid(core_cnt_valid),
        .core_code_valid(core_code_valid), .busy(busy), .res_valid(res_valid),
        .res_ack(res_ack), .err(err), .err_code(err_code), .frame_cnt(frame_cnt)
`ifdef HUFF_CTRL_PERF_EN
        , .perf_cycles(perf_cycles)
`endif
    );

    int cyc = 0;
    always @(posedge clk) cyc++;

    int n_pass = 0, n_total = 0;

    task automatic check(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    endtask

    typedef struct { int data; int at; } pix_t;
    typedef struct { int kind; int code; int fc; } ev_t;   // kind 0 done, 1 error
    pix_t pix_sb[$];
    ev_t  ev_sb[$];

    // Monitor
    pix_t mp;
    ev_t  me;
    int   run_len = 0, last_run = 0;
    logic prev_rv = 1'b0, prev_err = 1'b0;

    always @(negedge clk) begin
        if (core_gray_valid) begin
            run_len++;
            if (pix_sb.size() == 0) check("gray_unexpected", 1, 0);
            else begin
                mp = pix_sb.pop_front();
                check("gray_data", int'(core_gray_data), mp.data);
                check("gray_cycle", cyc, mp.at);
            end
        end else if (run_len != 0) begin
            last_run = run_len;
            run_len  = 0;
        end
        if (res_valid && !prev_rv) begin
            if (ev_sb.size() == 0) check("res_unexpected", 1, 0);
            else begin
                me = ev_sb.pop_front();
                check("res_kind", 0, me.kind);
                check("res_frame_cnt", int'(frame_cnt), me.fc);
            end
        end
        if (err && !prev_err) begin
            if (ev_sb.size() == 0) check("err_unexpected", 1, 0);
            else begin
                me = ev_sb.pop_front();
                check("err_kind", 1, me.kind);
                check("err_code", int'(err_code), me.code);
                check("err_busy", int'(busy), 0);
                check("err_core_rst", int'(core_rst), 1);
            end
        end
        prev_rv  = res_valid;
        prev_err = err;
    end

    // Driver
    int exp_fc = 0;
    int seed = 3;
    int feed_first = 0;

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic start_pulse();
        start = 1'b1; tick(); start = 1'b0;
    endtask

    task automatic feed(input int n, input int start_at);
        int w = 0;
        while (!pix_ready && w < 20) begin tick(); w++; end
        check("feed_ready", int'(pix_ready), 1);
        feed_first = cyc;
        for (int i = 0; i < n; i++) begin
            pix_valid = 1'b1;
            pix_data  = 8'((i * 37 + seed) & 255);
            pix_sb.push_back('{int'(pix_data), cyc + 1});
            if (i == start_at) start = 1'b1;
            tick();
            start = 1'b0;
        end
        pix_valid = 1'b0;
        seed += 11;
    endtask

    task automatic core_resp(input int cnt_dly, input int code_dly);
        repeat (cnt_dly) tick();
        core_cnt_valid = 1'b1; tick(); core_cnt_valid = 1'b0;
        repeat (code_dly) tick();
        core_code_valid = 1'b1; tick(); core_code_valid = 1'b0;
    endtask

    task automatic wait_res();
        int w = 0;
        while (!res_valid && w < 60) begin tick(); w++; end
        check("res_valid_seen", int'(res_valid), 1);
    endtask

    task automatic ack();
        res_ack = 1'b1; tick(); res_ack = 1'b0;
        exp_fc = (exp_fc + 1) % 256;
        check("frame_cnt", int'(frame_cnt), exp_fc);
        check("idle_core_rst", int'(core_rst), 1);
        check("idle_busy", int'(busy), 0);
        check("idle_res_valid", int'(res_valid), 0);
    endtask

    task automatic good_frame(input int cnt_dly, input int code_dly, input int start_at,
                              input bit hold_start);
        ev_sb.push_back('{0, 0, exp_fc});
        start_pulse();
        feed(FL, start_at);
        core_resp(cnt_dly, code_dly);
        wait_res();
        if (hold_start) begin
            start_pulse();
            check("hold_start_res_valid", int'(res_valid), 1);
            check("hold_start_busy", int'(busy), 1);
        end
        ack();
    endtask

    task automatic wait_err(output int elapsed, input int from);
        int w = 0;
        while (!err && w < 40) begin tick(); w++; end
        check("err_seen", int'(err), 1);
        elapsed = cyc - from;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        int e, el, c;
        reset = 1'b1; start = 1'b0; pix_valid = 1'b0; pix_data = '0;
        core_cnt_valid = 1'b0; core_code_valid = 1'b0; res_ack = 1'b0;
        repeat (3) tick();
        check("rst_core_rst", int'(core_rst), 1);
        check("rst_pix_ready", int'(pix_ready), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_gray_valid", int'(core_gray_valid), 0);
        check("rst_res_valid", int'(res_valid), 0);
        check("rst_err", int'(err), 0);
        check("rst_err_code", int'(err_code), 0);
        check("rst_frame_cnt", int'(frame_cnt), 0);
        reset = 1'b0;
        tick();

        // Basic frame.
        good_frame(3, 7, -1, 1'b0);
        check("burst_len", last_run, FL);

        // Underrun after pixel 40, then recovery.
        ev_sb.push_back('{1, 1, 0});
        start_pulse();
        feed(40, -1);
        tick();
        check("underrun_err", int'(err), 1);
        check("underrun_busy", int'(busy), 0);
        check("underrun_core_rst", int'(core_rst), 1);
        good_frame(2, 4, -1, 1'b0);
        check("recover_err_clear", int'(err), 0);

        // Count timeout, with pix_valid driven while waiting.
        ev_sb.push_back('{1, 2, 0});
        start_pulse();
        feed(FL, -1);
        e = cyc;
        pix_valid = 1'b1;
        tick(); tick();
        check("wait_pix_ready", int'(pix_ready), 0);
        wait_err(el, e);
        pix_valid = 1'b0;
        check("cnt_timeout_cycles", el, TO + 1);

        // Code timeout.
        ev_sb.push_back('{1, 3, 0});
        start_pulse();
        feed(FL, -1);
        core_cnt_valid = 1'b1; tick(); core_cnt_valid = 1'b0;
        e = cyc;
        wait_err(el, e);
        check("code_timeout_cycles", el, TO + 1);

        // code_valid on the same cycle the timer reaches TIMEOUT.
        ev_sb.push_back('{0, 0, exp_fc});
        start_pulse();
        feed(FL, -1);
        core_cnt_valid = 1'b1; tick(); core_cnt_valid = 1'b0;
        repeat (TO) tick();
        core_code_valid = 1'b1; tick(); core_code_valid = 1'b0;
        wait_res();
        ack();

        // code_valid seen while still waiting for counts.
        ev_sb.push_back('{0, 0, exp_fc});
        start_pulse();
        feed(FL, -1);
        core_code_valid = 1'b1; tick(); core_code_valid = 1'b0;
        repeat (2) tick();
        core_cnt_valid = 1'b1; tick(); core_cnt_valid = 1'b0;
        wait_res();
        ack();

        // start ignored during FEED and HOLD.
        good_frame(1, 1, 10, 1'b1);
        check("ignore_burst_len", last_run, FL);

        // Reset mid-frame after pixel 50.
        start_pulse();
        feed(50, -1);
        reset = 1'b1; tick(); reset = 1'b0;
        exp_fc = 0;
        check("midrst_core_rst", int'(core_rst), 1);
        check("midrst_pix_ready", int'(pix_ready), 0);
        check("midrst_busy", int'(busy), 0);
        check("midrst_gray_valid", int'(core_gray_valid), 0);
        check("midrst_res_valid", int'(res_valid), 0);
        check("midrst_err", int'(err), 0);
        check("midrst_frame_cnt", int'(frame_cnt), 0);
        tick();

        // 256 frames: frame_cnt wraps back to 0.
        for (int f = 0; f < 256; f++) good_frame(0, 0, -1, 1'b0);
        check("wrap_zero", int'(frame_cnt), 0);

`ifdef HUFF_CTRL_PERF_EN
        ev_sb.push_back('{0, 0, exp_fc});
        start_pulse();
        feed(FL, -1);
        repeat (9) tick();
        core_cnt_valid = 1'b1; tick(); core_cnt_valid = 1'b0;
        repeat (9) tick();
        core_code_valid = 1'b1;
        c = cyc;
        tick();
        core_code_valid = 1'b0;
        wait_res();
        check("perf_span", int'(perf_cycles), c - feed_first + 1);
        repeat (3) tick();
        check("perf_hold", int'(perf_cycles), c - feed_first + 1);
        ack();
        check("perf_idle", int'(perf_cycles), c - feed_first + 1);
        start_pulse();
        tick();
        check("perf_clr", int'(perf_cycles), 0);
        reset = 1'b1; tick(); reset = 1'b0;
`else
        c = 0;
`endif

        repeat (3) tick();
        check("pix_sb_empty", pix_sb.size(), 0);
        check("ev_sb_empty", ev_sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
